// File: rtl/chunked_seq_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding,
// default geometry and the chunk-count helper.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    function automatic int chunkCount(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 0;
    endfunction

endpackage

// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for chunked_seq_adder; the producer and
// consumer of results share the master side, the adder takes the slave side.
interface chunked_seq_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, zero
    );
endinterface

// File: rtl/chunked_seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple slice shared by every cycle of the
// sequential add.
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock,
// LSB chunk first, carry held in a register between slices.
module chunked_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic               clk,
    input logic               rst,
    chunked_seq_adder_if.slave bus
);

    localparam int NCHUNK = chunkCount(WIDTH, CHUNK);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_badParams
            $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e           stateQ;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic [WIDTH-1:0] sumQ;
    logic [WIDTH-1:0] sumD;
    logic [CW-1:0]    cntQ;
    logic             carryQ;
    logic             inReadyQ;
    logic             outValidQ;
    logic             cOutQ;
    logic             overflowQ;
    logic             zeroQ;

    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK-1:0] chunkSum;
    logic             chunkCarry;
    logic             lastChunk;

    // Chunk mux: select the slice addressed by the counter and splice the
    // slice result back so the flags can see the complete final sum.
    always_comb begin
        aChunk = aQ[int'(cntQ)*CHUNK +: CHUNK];
        bChunk = bQ[int'(cntQ)*CHUNK +: CHUNK];
        sumD   = sumQ;
        sumD[int'(cntQ)*CHUNK +: CHUNK] = chunkSum;
    end

    assign lastChunk = (cntQ == CW'(NCHUNK - 1));

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (aChunk),
        .b     (bChunk),
        .c_in  (carryQ),
        .sum   (chunkSum),
        .c_out (chunkCarry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= ST_IDLE;
            aQ        <= '0;
            bQ        <= '0;
            sumQ      <= '0;
            cntQ      <= '0;
            carryQ    <= 1'b0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            cOutQ     <= 1'b0;
            overflowQ <= 1'b0;
            zeroQ     <= 1'b0;
        end else begin
            case (stateQ)
                ST_IDLE: begin
                    if (bus.in_valid && inReadyQ) begin
                        // Subtract is a + ~b + ~borrow, so invert b and the carry here.
                        aQ       <= bus.a;
                        bQ       <= bus.sub ? ~bus.b : bus.b;
                        carryQ   <= bus.c_in ^ bus.sub;
                        cntQ     <= '0;
                        inReadyQ <= 1'b0;
                        stateQ   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    sumQ   <= sumD;
                    carryQ <= chunkCarry;
                    cntQ   <= cntQ + 1'b1;
                    if (lastChunk) begin
                        cOutQ     <= chunkCarry;
                        overflowQ <= (aQ[WIDTH-1] == bQ[WIDTH-1]) &&
                                     (sumD[WIDTH-1] != aQ[WIDTH-1]);
                        zeroQ     <= (sumD == '0);
                        outValidQ <= 1'b1;
                        stateQ    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        outValidQ <= 1'b0;
                        inReadyQ  <= 1'b1;
                        stateQ    <= ST_IDLE;
                    end
                end
                default: begin
                    outValidQ <= 1'b0;
                    inReadyQ  <= 1'b1;
                    stateQ    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = outValidQ;
    assign bus.sum       = sumQ;
    assign bus.c_out     = cOutQ;
    assign bus.overflow  = overflowQ;
    assign bus.zero      = zeroQ;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder: directed 64/16 cases plus
// reference-model regressions on 8/2 and 64/64 instances.
module tb_chunked_seq_adder;
    import adder_pkg::*;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t qM[$];
    exp_t qS[$];
    exp_t qW[$];

    always #5 clk = ~clk;

    chunked_seq_adder_if #(.WIDTH(64)) busM ();
    chunked_seq_adder_if #(.WIDTH(8))  busS ();
    chunked_seq_adder_if #(.WIDTH(64)) busW ();

    chunked_seq_adder #(.WIDTH(64), .CHUNK(16)) dutM (.clk(clk), .rst(rst), .bus(busM));
    chunked_seq_adder #(.WIDTH(8),  .CHUNK(2))  dutS (.clk(clk), .rst(rst), .bus(busS));
    chunked_seq_adder #(.WIDTH(64), .CHUNK(64)) dutW (.clk(clk), .rst(rst), .bus(busW));

    // Plain full-width behavioural adder used as the reference model.
    function automatic exp_t refAdd(input logic [63:0] a, input logic [63:0] b,
                                     input logic cin, input logic sub, input int width);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] am;
        exp_t        e;
        mask   = (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
        am     = a & mask;
        bb     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bb} + 65'(cin ^ sub);
        e.a    = am;
        e.b    = b & mask;
        e.cin  = cin;
        e.sub  = sub;
        e.sum  = full[63:0] & mask;
        e.cout = full[width];
        e.ovf  = (am[width-1] == bb[width-1]) && (e.sum[width-1] != am[width-1]);
        e.zero = (e.sum == 64'd0);
        return e;
    endfunction

    function automatic exp_t mkExp(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input logic [63:0] sum,
                                   input logic cout, input logic ovf, input logic zero);
        exp_t e;
        e.a = a; e.b = b; e.cin = cin; e.sub = sub;
        e.sum = sum; e.cout = cout; e.ovf = ovf; e.zero = zero;
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e, input logic [63:0] sum,
                               input logic cout, input logic ovf, input logic zero);
        checks++;
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || zero !== e.zero) begin
            errors++;
            $display("[TB] FAIL %s: a=%h b=%h c_in=%0b sub=%0b got sum=%h c_out=%0b ovf=%0b zero=%0b, expected sum=%h c_out=%0b ovf=%0b zero=%0b",
                     name, e.a, e.b, e.cin, e.sub, sum, cout, ovf, zero,
                     e.sum, e.cout, e.ovf, e.zero);
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitors: pop one expected result per completed output handshake.
    always @(negedge clk) begin
        if (!rst && busM.out_valid && busM.out_ready) begin
            if (qM.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL mainUnexpected: out_valid with nothing pending, sum=%h", busM.sum);
            end else begin
                checkOutput("main", qM.pop_front(), busM.sum, busM.c_out, busM.overflow, busM.zero);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && busS.out_valid && busS.out_ready) begin
            if (qS.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL w8Unexpected: out_valid with nothing pending, sum=%h", busS.sum);
            end else begin
                checkOutput("w8c2", qS.pop_front(), 64'(busS.sum), busS.c_out, busS.overflow, busS.zero);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && busW.out_valid && busW.out_ready) begin
            if (qW.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL w64Unexpected: out_valid with nothing pending, sum=%h", busW.sum);
            end else begin
                checkOutput("w64c64", qW.pop_front(), busW.sum, busW.c_out, busW.overflow, busW.zero);
            end
        end
    end

    // Issue one operation to the 64/16 instance, optionally expecting its result.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                 input logic sub, input bit expectResult, input exp_t e);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        while (!busM.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!busM.in_ready) begin
            checks++; errors++;
            $display("[TB] FAIL mainAcceptTimeout: in_ready=%0b, expected 1", busM.in_ready);
            return;
        end
        busM.a = a; busM.b = b; busM.c_in = cin; busM.sub = sub; busM.in_valid = 1'b1;
        if (expectResult) qM.push_back(e);
        @(posedge clk);
        #1 busM.in_valid = 1'b0;
    endtask

    task automatic waitOutValid(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busM.out_valid) break;
        end
    endtask

    task automatic applyRegression(input int which, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        int waitCycles;
        logic rdy;
        waitCycles = 0;
        @(negedge clk);
        rdy = (which == 0) ? busS.in_ready : busW.in_ready;
        while (!rdy && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
            rdy = (which == 0) ? busS.in_ready : busW.in_ready;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("[TB] FAIL regAcceptTimeout: dut %0d in_ready=%0b, expected 1", which, rdy);
            return;
        end
        if (which == 0) begin
            busS.a = a[7:0]; busS.b = b[7:0]; busS.c_in = cin; busS.sub = sub; busS.in_valid = 1'b1;
            qS.push_back(refAdd(a, b, cin, sub, 8));
        end else begin
            busW.a = a; busW.b = b; busW.c_in = cin; busW.sub = sub; busW.in_valid = 1'b1;
            qW.push_back(refAdd(a, b, cin, sub, 64));
        end
        @(posedge clk);
        #1;
        busS.in_valid = 1'b0;
        busW.in_valid = 1'b0;
    endtask

    localparam logic [63:0] BP_SUM = 64'h2345_6789_ABCD_F001;

    initial begin
        int   n;
        exp_t none;
        none = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        busM.in_valid = 0; busM.a = 0; busM.b = 0; busM.c_in = 0; busM.sub = 0; busM.out_ready = 1;
        busS.in_valid = 0; busS.a = 0; busS.b = 0; busS.c_in = 0; busS.sub = 0; busS.out_ready = 1;
        busW.in_valid = 0; busW.a = 0; busW.b = 0; busW.c_in = 0; busW.sub = 0; busW.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkValue("resetInReady", busM.in_ready, 1);
        checkValue("resetOutValid", busM.out_valid, 0);
        checkValue("resetSum", busM.sum, 0);
        checkValue("resetFlags", {busM.c_out, busM.overflow, busM.zero}, 0);

        // Wrap-around and the four-chunk latency.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1,
                      mkExp(64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 64'd0, 1, 0, 1));
        waitOutValid(n);
        checkValue("latency", n, 4);

        applyStimulus(64'd5, 64'd7, 1'b0, 1'b1, 1,
                      mkExp(5, 7, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0));
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1,
                      mkExp(64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 64'h8000_0000_0000_0000, 0, 1, 0));
        applyStimulus(64'd10, 64'd3, 1'b1, 1'b1, 1, mkExp(10, 3, 1, 1, 64'd6, 1, 0, 0));
        applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1,
                      mkExp(64'h8000_0000_0000_0000, 1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0));
        applyStimulus(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 1,
                      mkExp(64'hFFFF, 1, 0, 0, 64'h0000_0000_0001_0000, 0, 0, 0));
        waitOutValid(n);

        // Backpressure with toggling operands while DONE is held.
        @(posedge clk);
        #1 busM.out_ready = 1'b0;
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1,
                      mkExp(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0, 0, BP_SUM, 0, 0, 0));
        waitOutValid(n);
        checkValue("bpReached", busM.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            busM.a = {$urandom, $urandom}; busM.b = {$urandom, $urandom};
            busM.sub = i[1]; busM.c_in = i[0]; busM.in_valid = i[0];
            @(negedge clk);
            checkValue("bpInReady", busM.in_ready, 0);
            checkValue("bpOutValid", busM.out_valid, 1);
            checkValue("bpSum", busM.sum, BP_SUM);
            checkValue("bpFlags", {busM.c_out, busM.overflow, busM.zero}, 0);
        end
        @(posedge clk);
        #1;
        busM.out_ready = 1'b1;
        busM.a = 64'd100; busM.b = 64'd23; busM.c_in = 0; busM.sub = 0; busM.in_valid = 1'b1;
        qM.push_back(mkExp(100, 23, 0, 0, 64'd123, 0, 0, 0));
        @(negedge clk);
        checkValue("doneNoAccept", busM.in_ready, 0);
        @(negedge clk);
        checkValue("releaseOutValid", busM.out_valid, 0);
        checkValue("releaseInReady", busM.in_ready, 1);
        @(posedge clk);
        #1 busM.in_valid = 1'b0;
        waitOutValid(n);
        checkValue("latencyAfterRelease", n, 4);

        // Reset during the second ADD cycle discards the operation.
        applyStimulus(64'd1, 64'd2, 1'b0, 1'b0, 0, none);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkValue("rstAddOutValid", busM.out_valid, 0);
        checkValue("rstAddSum", busM.sum, 0);
        checkValue("rstAddInReady", busM.in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkValue("rstAddNoResult", busM.out_valid, 0);
        end
        applyStimulus(64'd3, 64'd4, 1'b0, 1'b0, 1, mkExp(3, 4, 0, 0, 64'd7, 0, 0, 0));
        waitOutValid(n);
        checkValue("postResetDone", busM.out_valid, 1);

        // Regression on the narrow and single-chunk instances.
        applyRegression(0, 64'hFF, 64'd0, 1'b1, 1'b0);
        applyRegression(0, 64'h80, 64'h01, 1'b0, 1'b1);
        applyRegression(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            applyRegression(0, 64'($urandom), 64'($urandom), i[0], i[1]);
            applyRegression(1, {$urandom, $urandom}, {$urandom, $urandom}, i[0], i[1]);
        end

        repeat (20) @(negedge clk);
        checkValue("drainMain", 64'(qM.size()), 0);
        checkValue("drainW8", 64'(qS.size()), 0);
        checkValue("drainW64", 64'(qW.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the fixed 64-bit combinational adder.
- Operands are latched on a valid/ready handshake and added CHUNK bits per clock, least-significant chunk first, through a registered carry.
- The result is presented on an output valid/ready handshake, together with carry, signed-overflow and zero flags.
- Sits in the datapath wherever a wide add must meet timing at the cost of latency.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a positive multiple of CHUNK (elaboration error otherwise).
- CHUNK, 16, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam, number of add cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB (sub: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state IDLE, in_ready 1, out_valid 0, sum 0, c_out 0, overflow 0, zero 0, chunk counter 0, carry register 0.
- State IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch A = a, B = sub ? ~b : b, carry = c_in ^ sub, counter = 0; go to ADD.
- State ADD:
  - in_ready = 0.
  - Each cycle: {carry, sum[counter*CHUNK +: CHUNK]} = A chunk + B chunk + carry; counter increments.
  - After chunk NCHUNK-1 is written: c_out = final carry; overflow = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]) using the latched, inverted-if-sub B; zero = (full sum == 0); go to DONE.
- State DONE:
  - out_valid = 1; sum and flags held stable.
  - On out_ready: go to IDLE next cycle; out_valid drops.
- Latency: operands accepted at edge k; out_valid is high in the cycle following edge k+NCHUNK. Minimum initiation interval is NCHUNK+2 cycles.
- Arithmetic:
  - Subtract computes a - b - c_in = a + ~b + ~c_in, modulo 2^WIDTH.
  - NCHUNK == 1 degenerates to a single-cycle add followed by DONE.
- Operand isolation: changes on a, b, c_in, sub after acceptance are ignored. in_valid is ignored outside IDLE.
- Result visibility: sum bits may update during ADD; consumers sample only while out_valid = 1.
- Simultaneous events: in_valid asserted in DONE with out_ready is not accepted that cycle; it is accepted in the following IDLE cycle.
- Backpressure: out_ready low holds DONE indefinitely with outputs stable.
- Reset mid-operation: rst in any state forces the reset values on the next edge; any in-flight operation is discarded and no out_valid is produced for it.
- Wrap-around: the all-ones + 1 case yields sum 0, c_out 1, zero 1.

Decomposition:
- Shared package adder_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_ADD = 2'd1, ST_DONE = 2'd2;
  - default WIDTH/CHUNK constants;
  - a function computing chunk count.
- One combinational sub-module, chunk_adder (parameter CHUNK; ports a, b, c_in, sum, c_out), instantiated once and fed by a chunk mux on the counter.
- The existing full-width behavioural adder serves as the bench reference model.

Test Plan:
- WIDTH=64, CHUNK=16: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1, sub=0 -> sum=0, c_out=1, zero=1, overflow=0; out_valid exactly 4 cycles after accept edge.
- Subtract: a=5, b=7, c_in=0, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0, overflow=0, zero=0.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, overflow=1, c_out=0.
- Backpressure and isolation: hold out_ready=0 for 10 cycles with a, b toggling -> in_ready=0 throughout, sum/flags stable; out_ready=1 -> out_valid low next cycle, in_ready high.
- Reset in ADD: assert rst at the 2nd ADD cycle -> next cycle out_valid=0, sum=0, in_ready=1; a new op 3+4 then returns 7.
- Random regression at WIDTH=8/CHUNK=2 and WIDTH=64/CHUNK=64 covering all {sub, c_in}: result compared against the reference adder on every out_valid && out_ready; any mismatch displays the operands.
